multi_debouncer: RTL and testbench

- Parametrised N-channel push-button / switch conditioner for the digital lock front end. Successor to the single-button slow-clock debouncer.
- Each raw input is synchronised, then sampled on a shared internal tick. Its debounced level changes only after STABLE_CNT consecutive agreeing samples.
- Provides a debounced level plus single-cycle rise and fall pulses per channel, all in the main clk domain (no derived clocks).
- Feeds the keypad/entry FSM directly.

---
 rtl/lock_pkg.sv | 13 +
 rtl/debounce_channel.sv | 66 ++++++
 rtl/multi_debouncer.sv | 57 +++++
 tb/tb_multi_debouncer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared constants and helpers for the digital lock front end.
package lock_pkg;

   localparam int DEB_TICK_DIV   = 250000;
   localparam int DEB_STABLE_CNT = 4;
   localparam int N_BUTTONS      = 4;

   // $clog2 that never returns zero, so single-value counters keep one bit
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, agreement counter, level and
// single-cycle edge pulses. State advances only on the shared sample tick.
module debounce_channel
   import lock_pkg::*;
#(
   parameter int STABLE_CNT = DEB_STABLE_CNT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = clog2_min1(STABLE_CNT);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

   logic          s1;
   logic          syncd;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          level_n;
   logic          rise_n;
   logic          fall_n;

   always_comb begin
      cnt_n   = cnt;
      level_n = level;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      if (tick) begin
         if (syncd == level) begin
            cnt_n = '0;
         end else if (cnt == CMAX) begin
            level_n = syncd;
            cnt_n   = '0;
            rise_n  = syncd;
            fall_n  = ~syncd;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end
   end

   // pulses are rewritten every cycle so they never outlive one clk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         syncd <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1    <= raw;
         syncd <= s1;
         cnt   <= cnt_n;
         level <= level_n;
         rise  <= rise_n;
         fall  <= fall_n;
      end
   end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button conditioner: shared sample tick, input polarity mask
// and one debounce_channel per input.
module multi_debouncer
   import lock_pkg::*;
#(
   parameter int              N_CH       = N_BUTTONS,
   parameter int              TICK_DIV   = DEB_TICK_DIV,
   parameter int              STABLE_CNT = DEB_STABLE_CNT,
   parameter logic [N_CH-1:0] INV_MASK   = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] db_level,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic            tick_out
);

   localparam int TW = clog2_min1(TICK_DIV);
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

   logic [TW-1:0]   tcnt;
   logic            run;
   logic            tick;
   logic [N_CH-1:0] pb_eff;

   // run keeps the tick low while in reset, even when TICK_DIV is 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt <= '0;
         run  <= 1'b0;
      end else begin
         run  <= 1'b1;
         tcnt <= (tcnt == TMAX) ? '0 : tcnt + 1'b1;
      end
   end

   assign tick     = run && (tcnt == TMAX);
   assign tick_out = tick;
   assign pb_eff   = pb_in ^ INV_MASK;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CNT(STABLE_CNT)
      ) u_ch (
         .clk  (clk),
         .rst_n(rst_n),
         .tick (tick),
         .raw  (pb_eff[i]),
         .level(db_level[i]),
         .rise (rise_pulse[i]),
         .fall (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench: stimulus queues expected pulses, monitors pop and compare.
module tb_multi_debouncer;

   typedef struct {
      int         cyc;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] level;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] pb_a = 2'b10;
   logic [1:0] pb_b = 2'b00;
   logic [1:0] db_level_a, rise_a, fall_a;
   logic [1:0] db_level_b, rise_b, fall_b;
   logic       tick_out_a, tick_out_b;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   multi_debouncer #(
      .N_CH(2), .TICK_DIV(4), .STABLE_CNT(3), .INV_MASK(2'b10)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .pb_in(pb_a),
      .db_level(db_level_a), .rise_pulse(rise_a),
      .fall_pulse(fall_a), .tick_out(tick_out_a)
   );

   multi_debouncer #(
      .N_CH(2), .TICK_DIV(1), .STABLE_CNT(1), .INV_MASK(2'b00)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .pb_in(pb_b),
      .db_level(db_level_b), .rise_pulse(rise_b),
      .fall_pulse(fall_b), .tick_out(tick_out_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if ((rise_a | fall_a) != 2'b00) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_unexpected rise=%b fall=%b cyc=%0d",
                     rise_a, fall_a, cyc);
         end else begin
            ea = qa.pop_front();
            chk("a_cyc", cyc, ea.cyc);
            chk("a_rise", {30'd0, rise_a}, {30'd0, ea.rise});
            chk("a_fall", {30'd0, fall_a}, {30'd0, ea.fall});
            chk("a_level", {30'd0, db_level_a}, {30'd0, ea.level});
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if ((rise_b | fall_b) != 2'b00) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected rise=%b fall=%b cyc=%0d",
                     rise_b, fall_b, cyc);
         end else begin
            eb = qb.pop_front();
            chk("b_cyc", cyc, eb.cyc);
            chk("b_rise", {30'd0, rise_b}, {30'd0, eb.rise});
            chk("b_fall", {30'd0, fall_b}, {30'd0, eb.fall});
            chk("b_level", {30'd0, db_level_b}, {30'd0, eb.level});
         end
      end
   end

   // leaves the bench on a negedge whose following posedge is a tick edge
   task automatic align();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick_out_a && n < 16);
      if (!tick_out_a) chk("align_timeout", 32'd0, 32'd1);
   endtask

   // clean step: flip lands 2 sync clk + 3 ticks of 4 clk after the tick edge
   task automatic step_a(input logic [1:0] pb, input logic [1:0] r,
                         input logic [1:0] f, input logic [1:0] l,
                         input int wait_n);
      align();
      pb_a = pb;
      qa.push_back('{cyc + 13, r, f, l});
      repeat (wait_n) @(negedge clk);
   endtask

   logic [1:0] vb[5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
   int         hb[5] = '{4, 4, 4, 1, 4};
   logic [1:0] er[5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00};
   logic [1:0] ef[5] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b10};
   logic [1:0] el[5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00};

   initial begin
      int last;
      int nt;
      int c;

      repeat (3) @(negedge clk);
      chk("rst_level_a", {30'd0, db_level_a}, 32'd0);
      chk("rst_pulse_a", {30'd0, rise_a | fall_a}, 32'd0);
      chk("rst_tick_a", {31'd0, tick_out_a}, 32'd0);
      chk("rst_tick_b", {31'd0, tick_out_b}, 32'd0);
      chk("rst_level_b", {30'd0, db_level_b}, 32'd0);
      rst_n = 1'b1;

      last = -1;
      nt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         chk("tick_b_const", {31'd0, tick_out_b}, 32'd1);
         if (tick_out_a) begin
            if (last >= 0) chk("tick_gap", cyc - last, 32'd4);
            last = cyc;
            nt++;
         end
      end
      chk("tick_count", nt, 32'd25);
      chk("idle_level_a", {30'd0, db_level_a}, 32'd0);

      step_a(2'b11, 2'b01, 2'b00, 2'b01, 20);
      chk("lvl_after_rise", {30'd0, db_level_a}, 32'd1);
      step_a(2'b10, 2'b00, 2'b01, 2'b00, 20);

      align();
      c = cyc;
      qa.push_back('{c + 45, 2'b01, 2'b00, 2'b01});
      pb_a = 2'b11;
      repeat (8) @(negedge clk);
      pb_a = 2'b10;
      repeat (8) @(negedge clk);
      pb_a = 2'b11;
      repeat (8) @(negedge clk);
      pb_a = 2'b10;
      repeat (8) @(negedge clk);
      pb_a = 2'b11;
      repeat (30) @(negedge clk);
      chk("lvl_after_bounce", {30'd0, db_level_a}, 32'd1);

      step_a(2'b10, 2'b00, 2'b01, 2'b00, 20);
      step_a(2'b01, 2'b11, 2'b00, 2'b11, 20);
      chk("lvl_both", {30'd0, db_level_a}, 32'd3);
      step_a(2'b10, 2'b00, 2'b11, 2'b00, 20);

      // reset after two agreeing ticks; restart needs three fresh ticks
      align();
      c = cyc;
      pb_a = 2'b11;
      qa.push_back('{c + 22, 2'b01, 2'b00, 2'b01});
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("lvl_after_rst", {30'd0, db_level_a}, 32'd1);
      step_a(2'b10, 2'b00, 2'b01, 2'b00, 20);

      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         pb_b = vb[i];
         qb.push_back('{cyc + 3, er[i], ef[i], el[i]});
         repeat (hb[i]) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("b_final_level", {30'd0, db_level_b}, 32'd0);

      chk("qa_empty", qa.size(), 32'd0);
      chk("qb_empty", qb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
